// File: rtl/param_onehot_rr_arb_if.sv
// Request/grant bundle between X requesters, the arbiter and one downstream consumer.
// The slave modport is the arbiter side; master is the requester/consumer side.
interface param_onehot_rr_arb_if #(
    parameter int X = 2,
    parameter int W = 32
);
    localparam int PW = $clog2(X);

    logic [X-1:0]        i_valid;
    logic [X-1:0][W-1:0] i_data;
    logic [X-1:0]        o_ack;
    logic                o_valid;
    logic [W-1:0]        o_data;
    logic [X-1:0]        onehot;
    logic [PW-1:0]       o_src;
    logic                i_ready;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ack,
        output o_valid,
        output o_data,
        output onehot,
        output o_src
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ack,
        input  o_valid,
        input  o_data,
        input  onehot,
        input  o_src
    );
endinterface

// File: rtl/param_onehot_rr_arb.sv
// Round-robin arbiter feeding one registered output slot with one-hot grant.
// Define PARAM_ARB_STATS_EN to add grant and stall counters.
module param_onehot_rr_arb #(
    parameter int X = 2,
    parameter int W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
`ifdef PARAM_ARB_STATS_EN
    output logic [15:0]          o_grant_cnt,
    output logic [15:0]          o_stall_cnt,
`endif
    param_onehot_rr_arb_if.slave bus
);
    localparam int PW = $clog2(X);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  data_q, data_d;
    logic [X-1:0]  oh_q, oh_d;
    logic [PW-1:0] src_q, src_d;

    logic          full;
    logic          load_ok;
    logic          grant;
    logic          found;
    logic [PW-1:0] win;
    logic [PW:0]   idx;

    assign full    = (state_q == FULL);
    assign load_ok = !full || bus.i_ready;
    // Reset gates the grant so no requester sees an ack it cannot keep.
    assign grant   = load_ok && (|bus.i_valid) && !i_rst;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < X; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(X))
                idx = idx - (PW+1)'(X);
            if (!found && bus.i_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (bus.i_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.o_ack   = grant ? (X'(1) << win) : '0;
        bus.o_valid = full;
        bus.o_data  = data_q;
        bus.onehot  = oh_q;
        bus.o_src   = src_q;
    end

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        oh_d   = oh_q;
        src_d  = src_q;
        if (grant) begin
            ptr_d  = (win == PW'(X-1)) ? '0 : win + PW'(1);
            data_d = bus.i_data[win];
            oh_d   = X'(1) << win;
            src_d  = win;
        end else if (full && bus.i_ready) begin
            oh_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q  <= '0;
            data_q <= '0;
            oh_q   <= '0;
            src_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            oh_q   <= oh_d;
            src_q  <= src_d;
        end
    end

`ifdef PARAM_ARB_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant ? grant_cnt_q + 16'd1 : grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (full && !bus.i_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_grant_cnt = grant_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_param_onehot_rr_arb.sv
// Directed bench for param_onehot_rr_arb with X=4, W=32.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_param_onehot_rr_arb;
    localparam int X = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    param_onehot_rr_arb_if #(.X(X), .W(W)) bus ();

`ifdef PARAM_ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    param_onehot_rr_arb #(.X(X), .W(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
`ifdef PARAM_ARB_STATS_EN
        .o_grant_cnt (grant_cnt),
        .o_stall_cnt (stall_cnt),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 4'b1111;
        bus.i_ready = 1'b1;
        bus.i_data  = '0;
        step();
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if ({bus.o_ack, bus.o_valid, bus.onehot, bus.o_src} !== 11'd0) begin
                n_bad++;
                $display("FAIL reset c%0d ack=%b vld=%b oh=%b src=%0d want all 0",
                         c, bus.o_ack, bus.o_valid, bus.onehot, bus.o_src);
            end
            step();
        end
    endtask

    task automatic test_single();
        rst = 1'b0;
        bus.i_valid   = 4'b0100;
        bus.i_data[2] = 32'hDEADBEEF;
        bus.i_ready   = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_ack !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_ack got %b want 0100", bus.o_ack);
        end
        step();
        n_cmp++;
        if ({bus.o_valid, bus.o_data, bus.onehot, bus.o_src} !==
            {1'b1, 32'hDEADBEEF, 4'b0100, 2'd2}) begin
            n_bad++;
            $display("FAIL single_out vld=%b data=%h oh=%b src=%0d want 1 deadbeef 0100 2",
                     bus.o_valid, bus.o_data, bus.onehot, bus.o_src);
        end
        bus.i_valid = '0;
        step();
        n_cmp++;
        if ({bus.o_valid, bus.o_data, bus.onehot, bus.o_src} !==
            {1'b0, 32'hDEADBEEF, 4'b0000, 2'd2}) begin
            n_bad++;
            $display("FAIL drain vld=%b data=%h oh=%b src=%0d want 0 deadbeef 0000 2",
                     bus.o_valid, bus.o_data, bus.onehot, bus.o_src);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.i_data[0] = 32'hA0A0_0000;
        bus.i_data[1] = 32'hA1A1_1111;
        bus.i_data[2] = 32'hA2A2_2222;
        bus.i_data[3] = 32'hA3A3_3333;
        bus.i_valid   = 4'b1111;
        bus.i_ready   = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            n_cmp++;
            if (bus.o_ack !== exp_oh[n]) begin
                n_bad++;
                $display("FAIL rot_ack n%0d got %b want %b", n, bus.o_ack, exp_oh[n]);
            end
            step();
            n_cmp++;
            if ({bus.o_valid, bus.onehot, bus.o_src} !== {1'b1, exp_oh[n], exp_src[n]}) begin
                n_bad++;
                $display("FAIL rot_out n%0d vld=%b oh=%b src=%0d want 1 %b %0d",
                         n, bus.o_valid, bus.onehot, bus.o_src, exp_oh[n], exp_src[n]);
            end
        end
        n_cmp++;
        if (bus.o_data !== 32'hA0A0_0000) begin
            n_bad++;
            $display("FAIL rot_data got %h want a0a00000", bus.o_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.i_valid   = 4'b0001;
        bus.i_data[0] = 32'h12345678;
        bus.i_ready   = 1'b1;
        step();
        bus.i_ready   = 1'b0;
        bus.i_valid   = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (bus.o_ack !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_ack c%0d got %b want 0000", c, bus.o_ack);
            end
            step();
            n_cmp++;
            if ({bus.o_valid, bus.o_data, bus.onehot, bus.o_src} !==
                {1'b1, 32'h12345678, 4'b0001, 2'd0}) begin
                n_bad++;
                $display("FAIL bp_hold c%0d vld=%b data=%h oh=%b src=%0d want 1 12345678 0001 0",
                         c, bus.o_valid, bus.o_data, bus.onehot, bus.o_src);
            end
        end
        bus.i_ready   = 1'b1;
        bus.i_valid   = 4'b0010;
        bus.i_data[1] = 32'hCAFEF00D;
        #1;
        n_cmp++;
        if (bus.o_ack !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_release_ack got %b want 0010", bus.o_ack);
        end
        step();
        n_cmp++;
        if ({bus.o_data, bus.onehot, bus.o_src} !== {32'hCAFEF00D, 4'b0010, 2'd1}) begin
            n_bad++;
            $display("FAIL bp_release_out data=%h oh=%b src=%0d want cafef00d 0010 1",
                     bus.o_data, bus.onehot, bus.o_src);
        end
`ifdef PARAM_ARB_STATS_EN
        n_cmp++;
        if ({grant_cnt, stall_cnt} !== {16'd2, 16'd5}) begin
            n_bad++;
            $display("FAIL stats_cnt grant=%0d stall=%0d want 2 5", grant_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_wrap();
        bus.i_ready = 1'b1;
        bus.i_valid = 4'b1000;
        step();
        n_cmp++;
        if (bus.onehot !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_pre oh=%b want 1000", bus.onehot);
        end
        bus.i_valid = 4'b1001;
        #1;
        n_cmp++;
        if (bus.o_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_ack0 got %b want 0001", bus.o_ack);
        end
        step();
        n_cmp++;
        if ({bus.onehot, bus.o_src} !== {4'b0001, 2'd0}) begin
            n_bad++;
            $display("FAIL wrap_out0 oh=%b src=%0d want 0001 0", bus.onehot, bus.o_src);
        end
        #1;
        n_cmp++;
        if (bus.o_ack !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_ack3 got %b want 1000", bus.o_ack);
        end
        step();
        n_cmp++;
        if ({bus.onehot, bus.o_src} !== {4'b1000, 2'd3}) begin
            n_bad++;
            $display("FAIL wrap_out3 oh=%b src=%0d want 1000 3", bus.onehot, bus.o_src);
        end
    endtask

    task automatic test_reset_mid();
        bus.i_valid   = 4'b0100;
        bus.i_data[2] = 32'h55AA55AA;
        bus.i_ready   = 1'b1;
        step();
        bus.i_valid = 4'b1111;
        bus.i_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_ack !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_ack got %b want 0000", bus.o_ack);
        end
        step();
        n_cmp++;
        if ({bus.o_valid, bus.onehot, bus.o_src, bus.o_data} !== 39'd0) begin
            n_bad++;
            $display("FAIL rstmid_out vld=%b oh=%b src=%0d data=%h want all 0",
                     bus.o_valid, bus.onehot, bus.o_src, bus.o_data);
        end
`ifdef PARAM_ARB_STATS_EN
        n_cmp++;
        if ({grant_cnt, stall_cnt} !== 32'd0) begin
            n_bad++;
            $display("FAIL rstmid_stats grant=%0d stall=%0d want 0 0", grant_cnt, stall_cnt);
        end
`endif
        rst = 1'b0;
        bus.i_valid = 4'b1010;
        bus.i_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_ack !== 4'b0010) begin
            n_bad++;
            $display("FAIL rstmid_first_ack got %b want 0010", bus.o_ack);
        end
        step();
        n_cmp++;
        if ({bus.o_valid, bus.onehot, bus.o_src} !== {1'b1, 4'b0010, 2'd1}) begin
            n_bad++;
            $display("FAIL rstmid_first_out vld=%b oh=%b src=%0d want 1 0010 1",
                     bus.o_valid, bus.onehot, bus.o_src);
        end
    endtask

    initial begin
        bus.i_valid = '0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
